// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle between the execute/memory units and the register-file arbiter.
// Latency: none, signals only; the arbiter adds one registered stage on the rf_* side.
// Backpressure: per-source valid/ready; a source holds valid, addr and data until accepted.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 5
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_rd_addr;
   logic [NUM_REQ*XLEN-1:0]   req_rd_data;
   logic                      stall;
   logic                      rf_write_en;
   logic [ADDR_W-1:0]         rf_rd_addr;
   logic [XLEN-1:0]           rf_rd_data;
   logic [IDW-1:0]            grant_id;
   logic                      busy;

   // Write-back sources: raise requests, observe accepts and the register-file port.
   modport master (
      output req_valid, req_rd_addr, req_rd_data, stall,
      input  req_ready, rf_write_en, rf_rd_addr, rf_rd_data, grant_id, busy
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_rd_addr, req_rd_data, stall,
      output req_ready, rf_write_en, rf_rd_addr, rf_rd_data, grant_id, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between NUM_REQ write-back sources.
// Latency: 1 cycle from accept edge to rf_write_en; throughput 1 write per cycle.
// Backpressure: at most one req_ready high per cycle; none while stall or reset is high.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0]     r_rr_ptr;
   logic               r_write_en;
   logic [ADDR_W-1:0]  r_rd_addr;
   logic [XLEN-1:0]    r_rd_data;
   logic [IDW-1:0]     r_grant_id;

   logic               w_found;
   logic [IDW-1:0]     w_gnt_idx;
   logic               w_accept;
   logic [NUM_REQ-1:0] w_ready;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [XLEN-1:0]    w_sel_data;
   logic [IDW-1:0]     w_next_ptr;

   // Rotating priority search: first valid at or above rr_ptr, otherwise the lowest valid below it.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && bus.req_valid[i] && (IDW'(i) >= r_rr_ptr)) begin
            w_found   = 1'b1;
            w_gnt_idx = IDW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && bus.req_valid[i]) begin
            w_found   = 1'b1;
            w_gnt_idx = IDW'(i);
         end
      end
   end

   assign w_accept = w_found & ~bus.stall & ~reset;

   // One-hot ready for the granted source, and the granted source's address/data fields.
   always_comb begin
      w_ready    = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_idx == IDW'(i)) begin
            w_ready[i] = w_accept;
            w_sel_addr = bus.req_rd_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = bus.req_rd_data[i*XLEN +: XLEN];
         end
      end
   end

   assign w_next_ptr = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IDW'(1));

   // Output stage and pointer: capture the accepted write; x0 writes are consumed but never enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr   <= '0;
         r_write_en <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
         r_grant_id <= '0;
      end else if (w_accept) begin
         r_rr_ptr   <= w_next_ptr;
         r_write_en <= (w_sel_addr != '0);
         r_rd_addr  <= w_sel_addr;
         r_rd_data  <= w_sel_data;
         r_grant_id <= w_gnt_idx;
      end else begin
         r_write_en <= 1'b0;
      end
   end

   assign bus.req_ready   = w_ready;
   assign bus.rf_write_en = r_write_en;
   assign bus.rf_rd_addr  = r_rd_addr;
   assign bus.rf_rd_data  = r_rd_data;
   assign bus.grant_id    = r_grant_id;
   assign bus.busy        = |bus.req_valid;
endmodule
